// File: rtl/lcd_bus_monitor_if.sv
// Character-LCD bus as seen between the CPU-side writer and the bus monitor.
// Valid/ready: there is no ready; a transfer is valid on the EN falling edge, with RS/RW/data sampled in that cycle.
interface lcd_bus_monitor_if;
  logic       EN;
  logic       RW;
  logic       RS;
  logic [7:0] data;

  modport master (output EN, RW, RS, data);
  modport slave  (input  EN, RW, RS, data);
endinterface

// File: rtl/lcd_bus_monitor.sv
// HD44780-style bus monitor: latches transfers on EN fall and keeps a 2x16 shadow DDRAM
// plus controller state. It also models busy time and flags transfers that were dropped.
module lcd_bus_monitor #(
  parameter int BUSY_CYCLES = 2000,
  parameter int CLR_CYCLES  = 76500
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_bus_monitor_if.slave    bus,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_char,
  output logic [6:0]          cursor_addr,
  output logic                display_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                two_line,
  output logic                incr,
  output logic                busy,
  output logic                xfer_strobe,
  output logic                overrun
);

  localparam int MAX_CYC = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [3:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM,
    OP_DATA
  } op_e;

  logic             en_q;
  logic [6:0]       ac_q, ac_d;
  logic             incr_q, incr_d;
  logic             disp_q, disp_d;
  logic             curs_q, curs_d;
  logic             blink_q, blink_d;
  logic             two_q, two_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q;
  logic             overrun_q;
  logic [7:0]       shadow_q [32];

  logic             fall;
  logic             take;
  logic             drop;
  op_e              op;
  logic             wr_en;
  logic [4:0]       wr_idx;
  logic             clr_all;
  logic             busy_load;
  logic             busy_long;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] r;
    if (up) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h40)      r = 7'h27;
      else if (ac == 7'h00) r = 7'h67;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  // Addresses past column 39 of a line fold onto the start of the next line.
  function automatic logic [6:0] ddram_remap(input logic [6:0] a);
    logic [6:0] r;
    if (a >= 7'h28 && a <= 7'h3F) r = 7'h40;
    else if (a >= 7'h68)          r = 7'h00;
    else                          r = a;
    return r;
  endfunction

  assign fall = en_q & ~bus.EN;
  assign take = fall & ~busy_q & ~bus.RW;
  assign drop = fall & (busy_q | bus.RW);

  always_comb begin
    op = OP_NOP;
    if (bus.RS) begin
      op = OP_DATA;
    end else begin
      casez (bus.data)
        8'b1???????: op = OP_DDRAM;
        8'b01??????: op = OP_CGRAM;
        8'b001?????: op = OP_FUNC;
        8'b0001????: op = OP_SHIFT;
        8'b00001???: op = OP_DISP;
        8'b000001??: op = OP_ENTRY;
        8'b0000001?: op = OP_HOME;
        8'b00000001: op = OP_CLEAR;
        default:     op = OP_NOP;
      endcase
    end
  end

  // Only columns 0-15 of each line exist in the shadow; index is {line, column}.
  assign wr_idx = {ac_q[6], ac_q[3:0]};

  always_comb begin
    ac_d      = ac_q;
    incr_d    = incr_q;
    disp_d    = disp_q;
    curs_d    = curs_q;
    blink_d   = blink_q;
    two_d     = two_q;
    wr_en     = 1'b0;
    clr_all   = 1'b0;
    busy_load = 1'b0;
    busy_long = 1'b0;
    if (take) begin
      case (op)
        OP_DATA: begin
          wr_en     = (ac_q[5:4] == 2'b00);
          ac_d      = ac_step(ac_q, incr_q);
          busy_load = 1'b1;
        end
        OP_CLEAR: begin
          clr_all   = 1'b1;
          ac_d      = 7'h00;
          incr_d    = 1'b1;
          busy_load = 1'b1;
          busy_long = 1'b1;
        end
        OP_HOME: begin
          ac_d      = 7'h00;
          busy_load = 1'b1;
          busy_long = 1'b1;
        end
        OP_ENTRY: begin
          incr_d    = bus.data[1];
          busy_load = 1'b1;
        end
        OP_DISP: begin
          disp_d    = bus.data[2];
          curs_d    = bus.data[1];
          blink_d   = bus.data[0];
          busy_load = 1'b1;
        end
        OP_SHIFT: begin
          if (!bus.data[3]) ac_d = ac_step(ac_q, bus.data[2]);
          busy_load = 1'b1;
        end
        OP_FUNC: begin
          two_d     = bus.data[3];
          busy_load = 1'b1;
        end
        OP_CGRAM: begin
          busy_load = 1'b1;
        end
        OP_DDRAM: begin
          ac_d      = ddram_remap(bus.data[6:0]);
          busy_load = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Counter holds N-1 on the first busy cycle and busy drops after it reaches zero.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_load) begin
      busy_d = 1'b1;
      cnt_d  = busy_long ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      ac_q      <= 7'h00;
      incr_q    <= 1'b1;
      disp_q    <= 1'b0;
      curs_q    <= 1'b0;
      blink_q   <= 1'b0;
      two_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      en_q      <= bus.EN;
      ac_q      <= ac_d;
      incr_q    <= incr_d;
      disp_q    <= disp_d;
      curs_q    <= curs_d;
      blink_q   <= blink_d;
      two_q     <= two_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      strobe_q  <= take;
      overrun_q <= overrun_q | drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
    end else if (clr_all) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
    end else if (wr_en) begin
      shadow_q[wr_idx] <= bus.data;
    end
  end

  assign rd_char     = shadow_q[rd_addr];
  assign cursor_addr = ac_q;
  assign display_on  = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign two_line    = two_q;
  assign incr        = incr_q;
  assign busy        = busy_q;
  assign xfer_strobe = strobe_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: expected post-transfer state is queued per accepted
// transfer and compared when xfer_strobe fires; shadow contents are checked directly.
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, two_line, incr;
  logic       busy, xfer_strobe, overrun;

  int checks = 0;
  int passes = 0;
  logic [11:0] exp_q[$];
  logic [4:0]  fl;

  always #5 clk = ~clk;

  lcd_bus_monitor_if bus ();

  lcd_bus_monitor #(.BUSY_CYCLES(4), .CLR_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .two_line    (two_line),
    .incr        (incr),
    .busy        (busy),
    .xfer_strobe (xfer_strobe),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One EN pulse: high for a cycle, low at the next negedge; the fall registers on the following posedge.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      input logic acc, input logic [6:0] ac, input logic [4:0] f);
    @(negedge clk);
    bus.RS = rs;
    bus.RW = rw;
    bus.data = d;
    bus.EN = 1'b1;
    if (acc) exp_q.push_back({ac, f});
    @(negedge clk);
    bus.EN = 1'b0;
  endtask

  task automatic chk_char(input int idx, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = 5'(idx);
    #1;
    check($sformatf("rd_char[%0d]", idx), {24'h0, rd_char}, {24'h0, exp});
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (xfer_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_strobe: got strobe with ac=%0h expected no transfer at %0t",
                   cursor_addr, $time);
        end else begin
          e = exp_q.pop_front();
          check("xfer_state", {20'h0, cursor_addr, display_on, cursor_on, blink_on, two_line, incr},
                {20'h0, e});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] greet [4];
    logic [7:0] tail [6];
    logic [7:0] d;
    greet = '{8'h41, 8'h44, 8'h44, 8'h49};
    tail  = '{8'h2B, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    bus.EN = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.data = 8'h00;
    rd_addr = 5'd0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 32; i++) chk_char(i, 8'h20);
    check("rst_ac", {25'h0, cursor_addr}, 32'h0);
    check("rst_flags", {27'h0, display_on, cursor_on, blink_on, two_line, incr}, 32'h1);
    check("rst_busy_ovr", {30'h0, busy, overrun}, 32'h0);

    // Init and greeting
    xfer(0, 0, 8'h38, 1, 7'h00, 5'b00011); idle(8);
    xfer(0, 0, 8'h0E, 1, 7'h00, 5'b11011); idle(8);
    xfer(0, 0, 8'h01, 1, 7'h00, 5'b11011); idle(8);
    xfer(0, 0, 8'h06, 1, 7'h00, 5'b11011); idle(8);
    fl = 5'b11011;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 0, greet[i], 1, 7'(i + 1), fl); idle(8);
    end
    for (int i = 0; i < 4; i++) chk_char(i, greet[i]);
    check("greet_ac", {25'h0, cursor_addr}, 32'h4);

    // RW=1 is rejected: clear command must not act
    check("ovr_before_rw", {31'h0, overrun}, 32'h0);
    xfer(0, 1, 8'h01, 0, 7'h00, fl); idle(4);
    check("ovr_after_rw", {31'h0, overrun}, 32'h1);
    check("rw_ac", {25'h0, cursor_addr}, 32'h4);
    chk_char(0, 8'h41);

    // Line change
    xfer(0, 0, 8'hC0, 1, 7'h40, fl); idle(4);
    for (int i = 0; i < 16; i++) begin
      d = (i < 10) ? 8'h20 : tail[i - 10];
      xfer(1, 0, d, 1, 7'(7'h41 + i), fl); idle(4);
    end
    for (int i = 16; i < 26; i++) chk_char(i, 8'h20);
    for (int i = 26; i < 32; i++) chk_char(i, tail[i - 26]);
    check("line2_ac", {25'h0, cursor_addr}, 32'h50);

    // Wrap and off-screen
    xfer(0, 0, 8'hA7, 1, 7'h27, fl); idle(4);
    xfer(1, 0, 8'h58, 1, 7'h40, fl); idle(4);
    check("wrap_ac", {25'h0, cursor_addr}, 32'h40);
    chk_char(7, 8'h20);
    chk_char(23, 8'h20);
    fl = 5'b11010;
    xfer(0, 0, 8'h04, 1, 7'h40, fl); idle(4);
    xfer(0, 0, 8'h80, 1, 7'h00, fl); idle(4);
    xfer(1, 0, 8'h59, 1, 7'h67, fl); idle(4);
    chk_char(0, 8'h59);
    check("dec_wrap_ac", {25'h0, cursor_addr}, 32'h67);

    // Shift, entry, set-DDRAM remap, function set, display control, CGRAM
    xfer(0, 0, 8'h14, 1, 7'h00, fl); idle(4);
    xfer(0, 0, 8'h10, 1, 7'h67, fl); idle(4);
    xfer(0, 0, 8'h18, 1, 7'h67, fl); idle(4);
    fl = 5'b11011;
    xfer(0, 0, 8'h07, 1, 7'h67, fl); idle(4);
    xfer(0, 0, 8'hB0, 1, 7'h40, fl); idle(4);
    xfer(0, 0, 8'hF0, 1, 7'h00, fl); idle(4);
    xfer(0, 0, 8'hA8, 1, 7'h40, fl); idle(4);
    xfer(0, 0, 8'hE7, 1, 7'h67, fl); idle(4);
    fl = 5'b11001;
    xfer(0, 0, 8'h20, 1, 7'h67, fl); idle(4);
    fl = 5'b10101;
    xfer(0, 0, 8'h0D, 1, 7'h67, fl); idle(4);
    fl = 5'b10111;
    xfer(0, 0, 8'h28, 1, 7'h67, fl); idle(4);
    xfer(0, 0, 8'h40, 1, 7'h67, fl); idle(4);

    // NOP starts no busy: a write 2 cycles later is accepted
    xfer(0, 0, 8'h80, 1, 7'h00, fl); idle(4);
    xfer(0, 0, 8'h00, 1, 7'h00, fl);
    xfer(1, 0, 8'h57, 1, 7'h01, fl);
    // Fall at t+N is dropped, fall at t+N+2 accepted
    idle(2);
    xfer(1, 0, 8'h56, 0, 7'h00, fl);
    xfer(1, 0, 8'h55, 1, 7'h02, fl);
    // Fall exactly at t+N+1 is accepted
    idle(3);
    xfer(1, 0, 8'h53, 1, 7'h03, fl); idle(4);
    chk_char(0, 8'h57);
    chk_char(1, 8'h55);
    chk_char(2, 8'h53);

    // Clear then a write 5 cycles later is dropped
    xfer(0, 0, 8'h01, 1, 7'h00, fl); idle(3);
    xfer(1, 0, 8'h52, 0, 7'h00, fl); idle(8);
    chk_char(0, 8'h20);
    chk_char(1, 8'h20);
    chk_char(26, 8'h20);
    check("clr_ac", {25'h0, cursor_addr}, 32'h0);
    xfer(1, 0, 8'h52, 1, 7'h01, fl); idle(4);
    chk_char(0, 8'h52);
    // Home keeps shadow and holds busy for the long period
    xfer(0, 0, 8'h02, 1, 7'h00, fl); idle(5);
    xfer(1, 0, 8'h5A, 0, 7'h00, fl); idle(8);
    chk_char(0, 8'h52);
    check("home_ac", {25'h0, cursor_addr}, 32'h0);

    // Async reset mid-busy with EN high through release
    xfer(1, 0, 8'h51, 1, 7'h01, fl);
    @(negedge clk);
    bus.EN = 1'b1;
    @(negedge clk);
    check("busy_before_rst", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {23'h0, busy, overrun, xfer_strobe, cursor_addr}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("rst_no_busy", {31'h0, busy}, 32'h0);
    chk_char(0, 8'h20);
    @(negedge clk);
    bus.RS = 1'b1; bus.RW = 1'b0; bus.data = 8'h50;
    exp_q.push_back({7'h01, 5'b00001});
    bus.EN = 1'b0;
    xfer(1, 0, 8'h4F, 0, 7'h00, 5'b00001);
    idle(2);
    check("ovr_after_rst_drop", {31'h0, overrun}, 32'h1);
    idle(4);
    chk_char(0, 8'h50);
    chk_char(1, 8'h20);
    check("final_ac", {25'h0, cursor_addr}, 32'h1);

    idle(2);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
